// File: rtl/regfile_wb_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler_pkg
// Description : Shared constants and helpers for the register-file write-back
//               scheduler: bank encodings, source indices, zero registers.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_scheduler_pkg;

    // Destination bank encodings (2'b11 is folded onto RF_NONE)
    localparam logic [1:0] RF_NONE = 2'b00;
    localparam logic [1:0] RF_INT  = 2'b01;
    localparam logic [1:0] RF_FPU  = 2'b10;

    // Write-back source indices on the wb_* vectors
    localparam int SRC_ALU = 0;
    localparam int SRC_FPU = 1;
    localparam int SRC_MEM = 2;
    localparam int NUM_SRC = 3;

    // Hard-wired registers that never carry a scoreboard entry
    localparam logic [4:0] ZERO_INT = 5'd0;
    localparam logic [4:0] ZERO_FPU = 5'd30;

    // The unused 2'b11 bank code behaves exactly like "no destination"
    function automatic logic [1:0] rf_norm(input logic [1:0] rf);
        return (rf == 2'b11) ? RF_NONE : rf;
    endfunction

    // True when (bank, idx) names the zero register of that bank
    function automatic logic is_zero_reg(input logic [1:0] rf, input logic [4:0] idx);
        return ((rf == RF_INT) && (idx == ZERO_INT)) ||
               ((rf == RF_FPU) && (idx == ZERO_FPU));
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_scheduler_rr_arbiter3.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter3
// Description : Three-way round-robin arbiter. The search starts at the
//               pointer; a grant moves the pointer just past the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter3 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [2:0] req,
    output logic [2:0] gnt
);

    logic [1:0] r_ptr;
    logic [2:0] w_gnt;

    // Pick the first requester at or after the pointer, wrapping around
    always_comb begin
        w_gnt = 3'b000;
        case (r_ptr)
            2'd1: begin
                if      (req[1]) w_gnt = 3'b010;
                else if (req[2]) w_gnt = 3'b100;
                else if (req[0]) w_gnt = 3'b001;
            end
            2'd2: begin
                if      (req[2]) w_gnt = 3'b100;
                else if (req[0]) w_gnt = 3'b001;
                else if (req[1]) w_gnt = 3'b010;
            end
            default: begin
                if      (req[0]) w_gnt = 3'b001;
                else if (req[1]) w_gnt = 3'b010;
                else if (req[2]) w_gnt = 3'b100;
            end
        endcase
    end

    // No grant may leak out while the pipeline is held in reset
    assign gnt = rstn ? w_gnt : 3'b000;

    // Advance the pointer to the source after the winner; idle keeps it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ptr <= 2'd0;
        end else if (gnt[0]) begin
            r_ptr <= 2'd1;
        end else if (gnt[1]) begin
            r_ptr <= 2'd2;
        end else if (gnt[2]) begin
            r_ptr <= 2'd0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Arbitrates ALU/FPU/MEM write-backs onto the single register
//               file write port and keeps a per-register pending-write
//               scoreboard for both banks so decode can stall on hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RBITS = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 issue_valid_i,
    input  logic [RBITS-1:0]     issue_rd_i,
    input  logic [1:0]           issue_rf_i,
    input  logic [RBITS-1:0]     issue_rs1_i,
    input  logic [RBITS-1:0]     issue_rs2_i,
    input  logic                 issue_rs1_fpu_i,
    input  logic                 issue_rs2_fpu_i,
    output logic                 hazard_o,
    input  logic [2:0]           wb_valid_i,
    input  logic [3*RBITS-1:0]   wb_rd_i,
    input  logic [5:0]           wb_rf_i,
    input  logic [3*XLEN-1:0]    wb_data_i,
    output logic [2:0]           wb_ready_o,
    output logic [RBITS-1:0]     rd_wb,
    output logic [1:0]           regwrite_wb,
    output logic [XLEN-1:0]      write_data_register_wb,
    output logic [31:0]          busy_int_o,
    output logic [31:0]          busy_fpu_o,
    output logic                 err_o
);

    // ------------------------------------------------------------------
    // Arbitration and write-port capture
    // ------------------------------------------------------------------
    logic [2:0]       w_gnt;
    logic             w_xfer;
    logic [RBITS-1:0] w_sel_rd;
    logic [1:0]       w_sel_rf;
    logic [XLEN-1:0]  w_sel_data;

    logic [RBITS-1:0] r_rd_wb;
    logic [1:0]       r_regwrite;
    logic [XLEN-1:0]  r_wdata;

    rr_arbiter3 u_arb (
        .clk  (clk),
        .rstn (rstn),
        .req  (wb_valid_i),
        .gnt  (w_gnt)
    );

    assign wb_ready_o = w_gnt;
    assign w_xfer     = |w_gnt;

    // Steer the granted source's payload towards the write-port registers
    always_comb begin
        w_sel_rd   = '0;
        w_sel_rf   = RF_NONE;
        w_sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_gnt[i]) begin
                w_sel_rd   = wb_rd_i[i*RBITS +: RBITS];
                w_sel_rf   = rf_norm(wb_rf_i[2*i +: 2]);
                w_sel_data = wb_data_i[i*XLEN +: XLEN];
            end
        end
    end

    // Write port: enable pulses for one cycle per transfer, index/data hold
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_wb    <= '0;
            r_regwrite <= RF_NONE;
            r_wdata    <= '0;
        end else if (w_xfer) begin
            r_rd_wb    <= w_sel_rd;
            r_regwrite <= w_sel_rf;
            r_wdata    <= w_sel_data;
        end else begin
            r_regwrite <= RF_NONE;
        end
    end

    assign rd_wb                  = r_rd_wb;
    assign regwrite_wb            = r_regwrite;
    assign write_data_register_wb = r_wdata;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [31:0] r_busy_int;
    logic [31:0] r_busy_fpu;
    logic        r_err;

    logic [1:0]  w_issue_rf;
    logic [31:0] w_wp_mask;
    logic [31:0] w_byp_int, w_byp_fpu;
    logic [31:0] w_avail_int, w_avail_fpu;
    logic        w_rs1_busy, w_rs2_busy, w_rd_busy;
    logic        w_set_en, w_clr_en;
    logic [31:0] w_set_int, w_set_fpu;
    logic [31:0] w_clr_int, w_clr_fpu;
    logic        w_err_hit;

    assign w_issue_rf = rf_norm(issue_rf_i);
    assign w_wp_mask  = 32'd1 << r_rd_wb;

    // The register sitting on the write port is bypassed by the register
    // file, so it no longer counts as pending for hazard purposes
    assign w_byp_int   = (r_regwrite == RF_INT) ? w_wp_mask : '0;
    assign w_byp_fpu   = (r_regwrite == RF_FPU) ? w_wp_mask : '0;
    assign w_avail_int = r_busy_int & ~w_byp_int;
    assign w_avail_fpu = r_busy_fpu & ~w_byp_fpu;

    assign w_rs1_busy = issue_rs1_fpu_i ? w_avail_fpu[issue_rs1_i] : w_avail_int[issue_rs1_i];
    assign w_rs2_busy = issue_rs2_fpu_i ? w_avail_fpu[issue_rs2_i] : w_avail_int[issue_rs2_i];
    assign w_rd_busy  = (w_issue_rf == RF_INT) ? w_avail_int[issue_rd_i] :
                        (w_issue_rf == RF_FPU) ? w_avail_fpu[issue_rd_i] : 1'b0;

    assign hazard_o = issue_valid_i & (w_rs1_busy | w_rs2_busy | w_rd_busy);

    // A new producer is only recorded when decode actually advances
    assign w_set_en  = issue_valid_i & ~hazard_o & (w_issue_rf != RF_NONE) &
                       ~is_zero_reg(w_issue_rf, issue_rd_i);
    assign w_set_int = (w_set_en && (w_issue_rf == RF_INT)) ? (32'd1 << issue_rd_i) : '0;
    assign w_set_fpu = (w_set_en && (w_issue_rf == RF_FPU)) ? (32'd1 << issue_rd_i) : '0;

    // The write committing this cycle retires its scoreboard entry
    assign w_clr_en  = (r_regwrite != RF_NONE) && !is_zero_reg(r_regwrite, r_rd_wb);
    assign w_clr_int = (w_clr_en && (r_regwrite == RF_INT)) ? w_wp_mask : '0;
    assign w_clr_fpu = (w_clr_en && (r_regwrite == RF_FPU)) ? w_wp_mask : '0;
    assign w_err_hit = (|(w_clr_int & ~r_busy_int)) | (|(w_clr_fpu & ~r_busy_fpu));

    // Clear then set, so a same-edge reissue keeps the register pending
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_busy_int <= '0;
            r_busy_fpu <= '0;
            r_err      <= 1'b0;
        end else begin
            r_busy_int <= (r_busy_int & ~w_clr_int) | w_set_int;
            r_busy_fpu <= (r_busy_fpu & ~w_clr_fpu) | w_set_fpu;
            if (w_err_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy_int_o = r_busy_int;
    assign busy_fpu_o = r_busy_fpu;
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_scheduler
// Description : Directed scenarios plus a randomized run against a
//               behavioural scoreboard model of the write-back scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rstn;
    logic        iv;
    logic [4:0]  ird, irs1, irs2;
    logic [1:0]  irf;
    logic        irs1f, irs2f;
    logic        hazard;
    logic [2:0]  wbv;
    logic [14:0] wbrd;
    logic [5:0]  wbrf;
    logic [95:0] wbdata;
    logic [2:0]  ready;
    logic [4:0]  rd_wb;
    logic [1:0]  regwrite_wb;
    logic [31:0] wdata;
    logic [31:0] busy_int, busy_fpu;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Source-side state (each source holds its request until granted)
    logic        sv    [0:2];
    logic [4:0]  srd   [0:2];
    logic [1:0]  srf   [0:2];
    logic [31:0] sdata [0:2];

    always #5 clk = ~clk;

    regfile_wb_scheduler dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .issue_valid_i          (iv),
        .issue_rd_i             (ird),
        .issue_rf_i             (irf),
        .issue_rs1_i            (irs1),
        .issue_rs2_i            (irs2),
        .issue_rs1_fpu_i        (irs1f),
        .issue_rs2_fpu_i        (irs2f),
        .hazard_o               (hazard),
        .wb_valid_i             (wbv),
        .wb_rd_i                (wbrd),
        .wb_rf_i                (wbrf),
        .wb_data_i              (wbdata),
        .wb_ready_o             (ready),
        .rd_wb                  (rd_wb),
        .regwrite_wb            (regwrite_wb),
        .write_data_register_wb (wdata),
        .busy_int_o             (busy_int),
        .busy_fpu_o             (busy_fpu),
        .err_o                  (err)
    );

    // ---------------- stimulus helpers ----------------
    task automatic pack_src();
        for (int i = 0; i < 3; i++) begin
            wbv[i]              = sv[i];
            wbrd[i*5 +: 5]      = srd[i];
            wbrf[i*2 +: 2]      = srf[i];
            wbdata[i*32 +: 32]  = sdata[i];
        end
    endtask

    task automatic clear_inputs();
        iv = 1'b0; ird = '0; irf = 2'b00; irs1 = '0; irs2 = '0; irs1f = 1'b0; irs2f = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b0; srd[i] = '0; srf[i] = 2'b00; sdata[i] = '0;
        end
        pack_src();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) sv[i] = 1'b1;
        pack_src();
        iv = 1'b1; ird = 5'd3; irf = 2'b01;
        tick();
        tick();
        n_checks++; if (ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", ready); end
        n_checks++; if (regwrite_wb !== 2'b00) begin n_fail++; $display("FAIL reset_regwrite got=%b exp=00", regwrite_wb); end
        n_checks++; if (rd_wb !== 5'd0 || wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wport got rd=%0d data=%h exp 0/0", rd_wb, wdata); end
        n_checks++; if (busy_int !== 32'd0 || busy_fpu !== 32'd0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_sb got int=%h fpu=%h err=%b exp 0", busy_int, busy_fpu, err); end
        clear_inputs();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic_int();
        iv = 1'b1; ird = 5'd5; irf = 2'b01;
        #1;
        n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL basic_issue_hazard got=%b exp=0", hazard); end
        tick();
        iv = 1'b0;
        n_checks++; if (busy_int[5] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_set got=%b exp=1", busy_int[5]); end
        sv[0] = 1'b1; srd[0] = 5'd5; srf[0] = 2'b01; sdata[0] = 32'h1234;
        pack_src();
        #1;
        n_checks++; if (ready !== 3'b001) begin n_fail++; $display("FAIL basic_ready got=%b exp=001", ready); end
        tick();
        sv[0] = 1'b0; pack_src();
        n_checks++; if (regwrite_wb !== 2'b01 || rd_wb !== 5'd5 || wdata !== 32'h1234) begin
            n_fail++; $display("FAIL basic_wport got rf=%b rd=%0d data=%h exp 01/5/1234", regwrite_wb, rd_wb, wdata); end
        n_checks++; if (busy_int[5] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_hold got=%b exp=1", busy_int[5]); end
        tick();
        n_checks++; if (busy_int[5] !== 1'b0 || err !== 1'b0 || regwrite_wb !== 2'b00) begin
            n_fail++; $display("FAIL basic_clear got busy=%b err=%b rf=%b exp 0/0/00", busy_int[5], err, regwrite_wb); end
    endtask

    task automatic test_round_robin();
        logic [31:0] ed;
        logic [1:0]  erf;
        int          g;
        do_reset();
        srd[0] = 5'd0;  srf[0] = 2'b01;
        srd[1] = 5'd30; srf[1] = 2'b10;
        srd[2] = 5'd0;  srf[2] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b1; sdata[i] = 32'hA000_0000 | (i << 16);
        end
        pack_src();
        for (int n = 0; n < 7; n++) begin
            g = n % 3;
            #1;
            n_checks++; if (ready !== (3'b001 << g)) begin n_fail++; $display("FAIL rr_grant n=%0d got=%b exp=%b", n, ready, 3'b001 << g); end
            ed  = sdata[g];
            erf = srf[g];
            tick();
            n_checks++; if (regwrite_wb !== erf || wdata !== ed) begin
                n_fail++; $display("FAIL rr_wport n=%0d got rf=%b data=%h exp rf=%b data=%h", n, regwrite_wb, wdata, erf, ed); end
            sdata[g] = sdata[g] + 32'd1;
            pack_src();
        end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rr_err got=%b exp=0", err); end
        clear_inputs();
    endtask

    task automatic test_hazard_fpu();
        do_reset();
        iv = 1'b1; ird = 5'd7; irf = 2'b10;
        tick();
        n_checks++; if (busy_fpu[7] !== 1'b1) begin n_fail++; $display("FAIL haz_busy_set got=%b exp=1", busy_fpu[7]); end
        irf = 2'b00; irs1 = 5'd7; irs1f = 1'b1; irs2 = 5'd0; irs2f = 1'b0;
        #1;
        n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL haz_raw0 got=%b exp=1", hazard); end
        tick();
        n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL haz_raw1 got=%b exp=1", hazard); end
        sv[1] = 1'b1; srd[1] = 5'd7; srf[1] = 2'b10; sdata[1] = 32'h77;
        pack_src();
        #1;
        n_checks++; if (ready !== 3'b010 || hazard !== 1'b1) begin
            n_fail++; $display("FAIL haz_grant got ready=%b hz=%b exp 010/1", ready, hazard); end
        tick();
        sv[1] = 1'b0; pack_src();
        #1;
        n_checks++; if (regwrite_wb !== 2'b10 || rd_wb !== 5'd7 || hazard !== 1'b0) begin
            n_fail++; $display("FAIL haz_bypass got rf=%b rd=%0d hz=%b exp 10/7/0", regwrite_wb, rd_wb, hazard); end
        tick();
        n_checks++; if (busy_fpu[7] !== 1'b0 || hazard !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL haz_clear got busy=%b hz=%b err=%b exp 0/0/0", busy_fpu[7], hazard, err); end
        clear_inputs();
    endtask

    task automatic test_zero_regs();
        iv = 1'b1; ird = 5'd0; irf = 2'b01; irs1 = 5'd0; irs2 = 5'd30; irs2f = 1'b1;
        #1;
        n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL zero_int_hazard got=%b exp=0", hazard); end
        tick();
        ird = 5'd30; irf = 2'b10;
        #1;
        n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL zero_fpu_hazard got=%b exp=0", hazard); end
        tick();
        iv = 1'b0;
        n_checks++; if (busy_int !== 32'd0 || busy_fpu !== 32'd0) begin
            n_fail++; $display("FAIL zero_busy got int=%h fpu=%h exp 0/0", busy_int, busy_fpu); end
        sv[0] = 1'b1; srd[0] = 5'd0; srf[0] = 2'b01; sdata[0] = 32'h5;
        pack_src();
        tick();
        sv[0] = 1'b0; pack_src();
        n_checks++; if (regwrite_wb !== 2'b01 || rd_wb !== 5'd0) begin
            n_fail++; $display("FAIL zero_wport got rf=%b rd=%0d exp 01/0", regwrite_wb, rd_wb); end
        tick();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL zero_err got=%b exp=0", err); end
        clear_inputs();
    endtask

    task automatic test_err_sticky();
        n_checks++; if (busy_int[9] !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL err_pre got busy=%b err=%b exp 0/0", busy_int[9], err); end
        sv[0] = 1'b1; srd[0] = 5'd9; srf[0] = 2'b01; sdata[0] = 32'h99;
        pack_src();
        tick();
        sv[0] = 1'b0; pack_src();
        n_checks++; if (regwrite_wb !== 2'b01 || rd_wb !== 5'd9 || err !== 1'b0) begin
            n_fail++; $display("FAIL err_wport got rf=%b rd=%0d err=%b exp 01/9/0", regwrite_wb, rd_wb, err); end
        tick();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got=%b exp=1", err); end
        tick(); tick(); tick();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", err); end
        do_reset();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_reset got=%b exp=0", err); end
    endtask

    task automatic test_same_edge_and_reset();
        do_reset();
        iv = 1'b1; ird = 5'd4; irf = 2'b01;
        tick();
        iv = 1'b0;
        sv[0] = 1'b1; srd[0] = 5'd4; srf[0] = 2'b01; sdata[0] = 32'h44;
        pack_src();
        tick();
        sv[0] = 1'b0; pack_src();
        iv = 1'b1; ird = 5'd4; irf = 2'b01;
        #1;
        n_checks++; if (regwrite_wb !== 2'b01 || rd_wb !== 5'd4 || hazard !== 1'b0) begin
            n_fail++; $display("FAIL same_edge_issue got rf=%b rd=%0d hz=%b exp 01/4/0", regwrite_wb, rd_wb, hazard); end
        tick();
        iv = 1'b0;
        n_checks++; if (busy_int[4] !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL same_edge_busy got busy=%b err=%b exp 1/0", busy_int[4], err); end
        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b1; srd[i] = 5'd4; srf[i] = 2'b01; sdata[i] = 32'hBEEF_0000 + i;
        end
        pack_src();
        iv = 1'b1; ird = 5'd6; irf = 2'b01;
        tick();
        rstn = 1'b0;
        tick();
        n_checks++; if (ready !== 3'b000 || regwrite_wb !== 2'b00 || rd_wb !== 5'd0 || wdata !== 32'd0 ||
                        busy_int !== 32'd0 || busy_fpu !== 32'd0 || err !== 1'b0 || hazard !== 1'b0) begin
            n_fail++; $display("FAIL midreset got rdy=%b rf=%b rd=%0d d=%h bi=%h bf=%h err=%b hz=%b exp all 0",
                               ready, regwrite_wb, rd_wb, wdata, busy_int, busy_fpu, err, hazard); end
        clear_inputs();
        rstn = 1'b1;
        tick();
    endtask

    // ---------------- behavioural model for the random run ----------------
    bit          mb [0:2][0:31];   // [bank][reg] pending-write flag, bank 1=int 2=fpu
    bit          merr;
    int          mptr;
    bit [4:0]    mwrd;
    int          mwrf;             // bank being written this cycle, 0 = none
    bit [31:0]   mwdata;

    function automatic int bank_of(input logic [1:0] rf);
        return (rf == 2'b11) ? 0 : int'(rf);
    endfunction

    function automatic bit zero_reg(input int bank, input int r);
        return (bank == 1 && r == 0) || (bank == 2 && r == 30);
    endfunction

    function automatic bit pending(input int bank, input int r);
        if (bank < 1 || bank > 2) return 1'b0;
        if (mwrf == bank && int'(mwrd) == r) return 1'b0;
        return mb[bank][r];
    endfunction

    function automatic void model_clear();
        for (int b = 0; b < 3; b++)
            for (int r = 0; r < 32; r++) mb[b][r] = 1'b0;
        merr = 1'b0; mptr = 0; mwrd = '0; mwrf = 0; mwdata = '0;
    endfunction

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 11);
        if (r < 8)  return 5'(r);
        if (r < 10) return 5'd30;
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic test_random();
        int          last_g;
        int          g;
        bit          exp_h;
        logic [2:0]  exp_rdy;
        logic [31:0] ebi, ebf;
        int          ib;
        do_reset();
        model_clear();
        last_g = -1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            rstn = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (sv[i] && last_g == i) sv[i] = 1'b0;
                if (!sv[i] && $urandom_range(0, 99) < 45) begin
                    sv[i] = 1'b1; srd[i] = pick_reg(); srf[i] = 2'($urandom_range(0, 3)); sdata[i] = $urandom;
                end
                if (!rstn) sv[i] = 1'b0;
            end
            pack_src();
            iv = ($urandom_range(0, 1) == 1); ird = pick_reg(); irf = 2'($urandom_range(0, 3));
            irs1 = pick_reg(); irs2 = pick_reg(); irs1f = 1'($urandom_range(0, 1)); irs2f = 1'($urandom_range(0, 1));
            #1;
            ib    = bank_of(irf);
            exp_h = iv && (pending(irs1f ? 2 : 1, int'(irs1)) || pending(irs2f ? 2 : 1, int'(irs2)) ||
                           (ib != 0 && pending(ib, int'(ird))));
            g = -1;
            if (rstn) begin
                for (int k = 0; k < 3; k++)
                    if (g < 0 && sv[(mptr + k) % 3]) g = (mptr + k) % 3;
            end
            exp_rdy = (g < 0) ? 3'b000 : (3'b001 << g);
            for (int r = 0; r < 32; r++) begin
                ebi[r] = mb[1][r];
                ebf[r] = mb[2][r];
            end
            n_checks++; if (ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, ready, exp_rdy); end
            n_checks++; if (hazard !== exp_h) begin n_fail++; $display("FAIL rand_hazard cyc=%0d got=%b exp=%b", cyc, hazard, exp_h); end
            n_checks++; if (regwrite_wb !== 2'(mwrf) || rd_wb !== mwrd || wdata !== mwdata) begin
                n_fail++; $display("FAIL rand_wport cyc=%0d got rf=%b rd=%0d d=%h exp rf=%0d rd=%0d d=%h",
                                   cyc, regwrite_wb, rd_wb, wdata, mwrf, mwrd, mwdata); end
            n_checks++; if (busy_int !== ebi || busy_fpu !== ebf) begin
                n_fail++; $display("FAIL rand_busy cyc=%0d got int=%h fpu=%h exp int=%h fpu=%h", cyc, busy_int, busy_fpu, ebi, ebf); end
            n_checks++; if (err !== merr) begin n_fail++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", cyc, err, merr); end
            // Advance the model to the state after the coming rising edge
            if (!rstn) begin
                model_clear();
            end else begin
                if (mwrf != 0 && !zero_reg(mwrf, int'(mwrd))) begin
                    if (!mb[mwrf][mwrd]) merr = 1'b1;
                    mb[mwrf][mwrd] = 1'b0;
                end
                if (iv && !exp_h && ib != 0 && !zero_reg(ib, int'(ird))) mb[ib][ird] = 1'b1;
                if (g >= 0) begin
                    mwrd = srd[g]; mwrf = bank_of(srf[g]); mwdata = sdata[g];
                    mptr = (g + 1) % 3;
                end else begin
                    mwrf = 0;
                end
            end
            last_g = g;
        end
        @(negedge clk);
        clear_inputs();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        clear_inputs();
        test_reset();
        test_basic_int();
        test_round_robin();
        test_hazard_fpu();
        test_zero_regs();
        test_err_sticky();
        test_same_edge_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
